hcm_tagged: RTL and testbench

Parametrised successor to the hit count memory. Stores one NCOLS-bit layer-occupancy row per SSID row and sets individual column bits via a pipelined read-modify-write. Per-row event tags replace the per-write SSIDIsNew clear, so a new event needs only a one-cycle `newEvent` pulse. It sits between the SSID/hit router (writes) and the pattern-matching readout (reads).

---
 rtl/hcm_pkg.sv | 22 ++
 rtl/hcm_tag_ram.sv | 34 +++
 rtl/hcm_tagged.sv | 215 +++++++++++++++++++++
 tb/tb_hcm_tagged.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcm_pkg.sv
// hcm_pkg: shared definitions for the tagged hit count memory.
// Holds the default geometry, the controller state encoding and the stored row layout.
package hcm_pkg;

  localparam int unsigned DEF_NROWS   = 65536;
  localparam int unsigned DEF_NCOLS   = 16;
  localparam int unsigned DEF_EVTBITS = 4;

  typedef enum logic [1:0] {
    StInitSweep = 2'd0,
    StRun       = 2'd1,
    StWrapSweep = 2'd2
  } hcm_state_e;

  // Stored row for the default geometry; the top keeps tag and bits as separate
  // vectors so other widths work, but the packing order is the same: tag on top.
  typedef struct packed {
    logic [DEF_EVTBITS-1:0] tag;
    logic [DEF_NCOLS-1:0]   bits;
  } hcm_row_t;

endpackage

// File: rtl/hcm_tag_ram.sv
// hcm_tag_ram: simple dual-port RAM with one write port and one registered read port.
// The read returns the contents from before a same-cycle write to the same address.
// Contents are not reset.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, sampled on the rising edge
//   rdata  out  read data, valid the cycle after raddr
module hcm_tag_ram
  import hcm_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_NROWS,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH),
  parameter int unsigned DATA_BITS = DEF_EVTBITS + DEF_NCOLS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hcm_tagged.sv
// hcm_tagged: hit count memory with per-row event tags.
// Each row stores {tag, bits}; a row whose tag differs from the current event reads as zero,
// so advancing the event is a single pulse. Column bits are set by a two-stage
// read-modify-write with forwarding; tags wrap through a full clearing sweep.
//   clk, reset                 clock, asynchronous active-high reset
//   writeValid/writeReady      write handshake; writeRowIn, writeCol select the bit to set
//   readValid/readReady        read handshake; readRowIn selects the row
//   newEvent                   advance the event tag (ignored while busy)
//   rowValid, rowPassed,       read result two cycles after accept
//   rowReadOutput
//   eventID                    current event tag
//   busy                       clearing sweep in progress
module hcm_tagged
  import hcm_pkg::*;
#(
  parameter int unsigned NROWS        = DEF_NROWS,
  parameter int unsigned ROWINDEXBITS = $clog2(NROWS),
  parameter int unsigned NCOLS        = DEF_NCOLS,
  parameter int unsigned COLBITS      = $clog2(NCOLS),
  parameter int unsigned EVTBITS      = DEF_EVTBITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    writeValid,
  output logic                    writeReady,
  input  logic [ROWINDEXBITS-1:0] writeRowIn,
  input  logic [COLBITS-1:0]      writeCol,
  input  logic                    readValid,
  output logic                    readReady,
  input  logic [ROWINDEXBITS-1:0] readRowIn,
  input  logic                    newEvent,
  output logic                    rowValid,
  output logic [ROWINDEXBITS-1:0] rowPassed,
  output logic [NCOLS-1:0]        rowReadOutput,
  output logic [EVTBITS-1:0]      eventID,
  output logic                    busy
);

  localparam int unsigned               RowW    = EVTBITS + NCOLS;
  localparam logic [ROWINDEXBITS-1:0]   LastRow = ROWINDEXBITS'(NROWS - 1);
  localparam logic [EVTBITS-1:0]        MaxEvt  = {EVTBITS{1'b1}};

  hcm_state_e              state_q, state_d;
  logic [ROWINDEXBITS-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [EVTBITS-1:0]      evt_q, evt_d;
  logic                    sweeping;

  // Stage 1: request accepted last cycle, RAM data arriving now.
  logic                    s1_valid_q, s1_wr_q;
  logic [ROWINDEXBITS-1:0] s1_row_q;
  logic [COLBITS-1:0]      s1_col_q;
  logic [EVTBITS-1:0]      s1_tag_q;

  // Stage 2: request with the resolved stored row; writes commit here.
  logic                    s2_valid_q, s2_wr_q;
  logic [ROWINDEXBITS-1:0] s2_row_q;
  logic [COLBITS-1:0]      s2_col_q;
  logic [EVTBITS-1:0]      s2_tag_q;
  logic [EVTBITS-1:0]      s2_cur_tag_q;
  logic [NCOLS-1:0]        s2_cur_bits_q;

  // Last committed write: the RAM read is read-before-write, so a request read in the
  // same cycle as a commit picks the commit up from here one cycle later.
  logic                    wb_valid_q;
  logic [ROWINDEXBITS-1:0] wb_row_q;
  logic [EVTBITS-1:0]      wb_tag_q;
  logic [NCOLS-1:0]        wb_bits_q;

  logic                    acc_wr, acc_rd;
  logic [ROWINDEXBITS-1:0] req_row;
  logic [RowW-1:0]         ram_rdata, ram_wdata;
  logic [ROWINDEXBITS-1:0] ram_waddr;
  logic                    ram_we;
  logic [EVTBITS-1:0]      cur_tag;
  logic [NCOLS-1:0]        cur_bits;
  logic [NCOLS-1:0]        s2_old_bits, s2_new_bits;
  logic                    commit;

  assign sweeping = (state_q != StRun);
  assign acc_wr   = writeValid & ~sweeping;
  assign acc_rd   = readValid & ~sweeping & ~writeValid;
  assign req_row  = acc_wr ? writeRowIn : readRowIn;

  // Stale tags contribute nothing, so a new event never merges old bits.
  assign s2_old_bits = (s2_cur_tag_q == s2_tag_q) ? s2_cur_bits_q : '0;
  assign s2_new_bits = s2_old_bits | (NCOLS'(1) << s2_col_q);
  assign commit      = s2_valid_q & s2_wr_q;

  // Resolve the current stored value of the stage-1 row, newest source first.
  always_comb begin
    cur_tag  = ram_rdata[RowW-1:NCOLS];
    cur_bits = ram_rdata[NCOLS-1:0];
    if (commit && (s2_row_q == s1_row_q)) begin
      cur_tag  = s2_tag_q;
      cur_bits = s2_new_bits;
    end else if (wb_valid_q && (wb_row_q == s1_row_q)) begin
      cur_tag  = wb_tag_q;
      cur_bits = wb_bits_q;
    end
  end

  // A sweep owns the write port. Commits still in flight when it starts are dropped from
  // the RAM since the sweep clears every row anyway; their reads still see them by forwarding.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s2_row_q;
    ram_wdata = {s2_tag_q, s2_new_bits};
    if (sweeping) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_cnt_q;
      ram_wdata = '0;
    end else if (commit) begin
      ram_we = 1'b1;
    end
  end

  hcm_tag_ram #(
    .DEPTH    (NROWS),
    .ADDR_BITS(ROWINDEXBITS),
    .DATA_BITS(RowW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(req_row),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    evt_d       = evt_q;
    unique case (state_q)
      StInitSweep, StWrapSweep: begin
        if (sweep_cnt_q == LastRow) begin
          state_d     = StRun;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + ROWINDEXBITS'(1);
        end
      end
      StRun: begin
        if (newEvent) begin
          if (evt_q == MaxEvt) begin
            evt_d   = '0;
            state_d = StWrapSweep;
          end else begin
            evt_d = evt_q + EVTBITS'(1);
          end
        end
      end
      default: state_d = StInitSweep;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInitSweep;
      sweep_cnt_q <= '0;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      evt_q       <= evt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_wr_q       <= 1'b0;
      s1_row_q      <= '0;
      s1_col_q      <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_wr_q       <= 1'b0;
      s2_row_q      <= '0;
      s2_col_q      <= '0;
      s2_tag_q      <= '0;
      s2_cur_tag_q  <= '0;
      s2_cur_bits_q <= '0;
      wb_valid_q    <= 1'b0;
      wb_row_q      <= '0;
      wb_tag_q      <= '0;
      wb_bits_q     <= '0;
    end else begin
      s1_valid_q    <= acc_wr | acc_rd;
      s1_wr_q       <= acc_wr;
      s1_row_q      <= req_row;
      s1_col_q      <= writeCol;
      s1_tag_q      <= evt_q;
      s2_valid_q    <= s1_valid_q;
      s2_wr_q       <= s1_wr_q;
      s2_row_q      <= s1_row_q;
      s2_col_q      <= s1_col_q;
      s2_tag_q      <= s1_tag_q;
      s2_cur_tag_q  <= cur_tag;
      s2_cur_bits_q <= cur_bits;
      wb_valid_q    <= commit & ~sweeping;
      wb_row_q      <= s2_row_q;
      wb_tag_q      <= s2_tag_q;
      wb_bits_q     <= s2_new_bits;
    end
  end

  assign busy          = sweeping;
  assign writeReady    = ~sweeping;
  assign readReady     = ~sweeping & ~writeValid;
  assign rowValid      = s2_valid_q & ~s2_wr_q;
  assign rowPassed     = rowValid ? s2_row_q : '0;
  assign rowReadOutput = rowValid ? s2_old_bits : '0;
  assign eventID       = evt_q;

endmodule

// File: tb/tb_hcm_tagged.sv
// Testbench for hcm_tagged with a 64-row, 16-column, 2-bit-tag geometry.
// The reference model keeps one bit vector per row for the current event only:
// an accepted write ORs its bit in, an accepted read expects the vector two cycles later,
// and every event advance empties all rows.
module tb_hcm_tagged;

  localparam int NR = 64;
  localparam int RB = 6;
  localparam int NC = 16;
  localparam int CB = 4;
  localparam int EB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          writeValid = 1'b0, writeReady;
  logic [RB-1:0] writeRowIn = '0;
  logic [CB-1:0] writeCol = '0;
  logic          readValid = 1'b0, readReady;
  logic [RB-1:0] readRowIn = '0;
  logic          newEvent = 1'b0;
  logic          rowValid;
  logic [RB-1:0] rowPassed;
  logic [NC-1:0] rowReadOutput;
  logic [EB-1:0] eventID;
  logic          busy;

  always #5 clk = ~clk;

  hcm_tagged #(
    .NROWS       (NR),
    .ROWINDEXBITS(RB),
    .NCOLS       (NC),
    .COLBITS     (CB),
    .EVTBITS     (EB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .writeValid   (writeValid),
    .writeReady   (writeReady),
    .writeRowIn   (writeRowIn),
    .writeCol     (writeCol),
    .readValid    (readValid),
    .readReady    (readReady),
    .readRowIn    (readRowIn),
    .newEvent     (newEvent),
    .rowValid     (rowValid),
    .rowPassed    (rowPassed),
    .rowReadOutput(rowReadOutput),
    .eventID      (eventID),
    .busy         (busy)
  );

  typedef struct packed {
    logic [31:0]   cyc;
    logic [RB-1:0] row;
    logic [NC-1:0] data;
  } ret_t;

  ret_t          exp_q[$];
  ret_t          obs_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [NC-1:0] mbits [NR];
  int            mevt = 0;
  int            mbusy = 0;

  logic          last_busy, last_wrdy, last_rrdy;
  logic [EB-1:0] last_evt;
  logic          exp_busy_l, exp_wrdy_l, exp_rrdy_l;
  logic [EB-1:0] exp_evt_l;

  task automatic model_init();
    for (int r = 0; r < NR; r++) mbits[r] = '0;
    mevt  = 0;
    mbusy = NR;
    exp_q.delete();
  endtask

  // One clock cycle: sample outputs for the current inputs, advance the model, step the clock.
  task automatic tick();
    ret_t r;
    logic acc_w, acc_r;
    #1;
    if (rowValid) begin
      r.cyc = 32'(cyc); r.row = rowPassed; r.data = rowReadOutput;
      obs_q.push_back(r);
    end
    last_busy  = busy;
    last_wrdy  = writeReady;
    last_rrdy  = readReady;
    last_evt   = eventID;
    exp_busy_l = (mbusy > 0);
    exp_wrdy_l = !exp_busy_l;
    exp_rrdy_l = !exp_busy_l && !writeValid;
    exp_evt_l  = EB'(mevt);
    acc_w = writeValid && !exp_busy_l;
    acc_r = readValid && !exp_busy_l && !writeValid;
    if (acc_w) mbits[writeRowIn] = mbits[writeRowIn] | (NC'(1) << writeCol);
    if (acc_r) begin
      r.cyc = 32'(cyc + 2); r.row = readRowIn; r.data = mbits[readRowIn];
      exp_q.push_back(r);
    end
    if (newEvent && !exp_busy_l) begin
      for (int k = 0; k < NR; k++) mbits[k] = '0;
      if (mevt == (1 << EB) - 1) begin
        mevt  = 0;
        mbusy = NR;
      end else begin
        mevt = mevt + 1;
      end
    end else if (mbusy > 0) begin
      mbusy = mbusy - 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({rowValid, busy, writeReady, readReady} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/busy/wrdy/rrdy=%b required 0100",
               {rowValid, busy, writeReady, readReady});
    end
    n_cmp++;
    if ({eventID, rowPassed, rowReadOutput} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got evt=%0d row=%0d data=%h required 0", eventID, rowPassed,
               rowReadOutput);
    end
    @(negedge clk);
    reset = 1'b0;
    model_init();
    n = 0;
    while (n < 200) begin
      tick();
      n_cmp++;
      if (last_busy !== exp_busy_l || last_wrdy !== exp_wrdy_l) begin
        n_fail++;
        $display("FAIL init_busy cyc %0d: got busy=%b wrdy=%b required busy=%b wrdy=%b", cyc,
                 last_busy, last_wrdy, exp_busy_l, exp_wrdy_l);
      end
      if (!last_busy) break;
      n++;
    end
    n_cmp++;
    if (n !== NR) begin
      n_fail++;
      $display("FAIL init_sweep_len: got %0d required %0d", n, NR);
    end
    for (int i = 0; i < NR; i++) begin
      readValid = 1'b1; readRowIn = RB'(i);
      tick();
    end
    readValid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL init_reads count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data !== '0) begin
        n_fail++;
        $display("FAIL init_reads[%0d]: got cyc=%0d row=%0d data=%h required cyc=%0d row=%0d data=0",
                 i, obs_q[i].cyc, obs_q[i].row, obs_q[i].data, exp_q[i].cyc, exp_q[i].row);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int cols[4] = '{0, 3, 3, 15};
    readValid = 1'b1; readRowIn = 6'd5;
    writeValid = 1'b1; writeRowIn = 6'd5;
    for (int k = 0; k < 4; k++) begin
      writeCol = CB'(cols[k]);
      tick();
      n_cmp++;
      if (last_rrdy !== exp_rrdy_l || last_rrdy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_read_stall[%0d]: got readReady=%b required 0", k, last_rrdy);
      end
    end
    writeValid = 1'b0;
    tick();
    readValid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      n_fail++;
      $display("FAIL b2b count: got %0d required 1 (model %0d)", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data !== 16'h8009) begin
        n_fail++;
        $display("FAIL b2b_read: got cyc=%0d row=%0d data=%h required cyc=%0d row=5 data=8009",
                 obs_q[i].cyc, obs_q[i].row, obs_q[i].data, exp_q[i].cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_new_event();
    logic [NC-1:0] want[2] = '{16'h0000, 16'h0010};
    writeValid = 1'b1; writeRowIn = 6'd7; writeCol = 4'd2;
    tick();
    writeValid = 1'b0; newEvent = 1'b1;
    tick();
    newEvent = 1'b0; readValid = 1'b1; readRowIn = 6'd7;
    tick();
    n_cmp++;
    if (last_evt !== exp_evt_l) begin
      n_fail++;
      $display("FAIL new_event_id: got %0d required %0d", last_evt, exp_evt_l);
    end
    readValid = 1'b0; writeValid = 1'b1; writeCol = 4'd4;
    tick();
    writeValid = 1'b0; readValid = 1'b1;
    tick();
    readValid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() !== 2) begin
      n_fail++;
      $display("FAIL new_event count: got %0d required 2", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size() && i < 2) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data !== want[i]) begin
        n_fail++;
        $display("FAIL new_event_read[%0d]: got cyc=%0d data=%h required cyc=%0d data=%h", i,
                 obs_q[i].cyc, obs_q[i].data, exp_q[i].cyc, want[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    int guard, n;
    guard = 0;
    do begin
      newEvent = 1'b1;
      tick();
      n_cmp++;
      if (last_evt !== exp_evt_l || last_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_step[%0d]: got evt=%0d busy=%b required evt=%0d busy=0", guard,
                 last_evt, last_busy, exp_evt_l);
      end
      guard++;
    end while (mbusy == 0 && guard < 8);
    newEvent = 1'b0;
    n = 0;
    while (n < 200) begin
      newEvent = (mbusy > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n_cmp++;
      if (last_evt !== exp_evt_l || last_busy !== exp_busy_l) begin
        n_fail++;
        $display("FAIL wrap_sweep cyc %0d: got evt=%0d busy=%b required evt=%0d busy=%b", cyc,
                 last_evt, last_busy, exp_evt_l, exp_busy_l);
      end
      if (!last_busy) break;
      n++;
    end
    newEvent = 1'b0;
    n_cmp++;
    if (n !== NR) begin
      n_fail++;
      $display("FAIL wrap_sweep_len: got %0d required %0d", n, NR);
    end
    readValid = 1'b1; readRowIn = 6'd7;
    tick();
    readValid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() !== 1) begin
      n_fail++;
      $display("FAIL wrap_read count: got %0d required 1", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data !== '0) begin
        n_fail++;
        $display("FAIL wrap_read: got cyc=%0d data=%h required cyc=%0d data=0", obs_q[i].cyc,
                 obs_q[i].data, exp_q[i].cyc);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    writeValid = 1'b1; writeRowIn = 6'd9; writeCol = 4'd1;
    tick();
    writeCol = 4'd6;
    tick();
    writeValid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rowValid, busy, writeReady, readReady} !== 4'b0100 ||
        {eventID, rowPassed, rowReadOutput} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got v/b/w/r=%b evt=%0d row=%0d data=%h required 0100 0 0 0",
               {rowValid, busy, writeReady, readReady}, eventID, rowPassed, rowReadOutput);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
    n = 0;
    while (n < 200) begin
      tick();
      if (!last_busy) break;
      n++;
    end
    n_cmp++;
    if (n !== NR) begin
      n_fail++;
      $display("FAIL mid_reset_sweep_len: got %0d required %0d", n, NR);
    end
    for (int i = 0; i < NR; i++) begin
      readValid = 1'b1; readRowIn = RB'(i);
      tick();
    end
    readValid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() !== NR) begin
      n_fail++;
      $display("FAIL mid_reset_reads count: got %0d required %0d", obs_q.size(), NR);
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_read[%0d]: got cyc=%0d row=%0d data=%h required cyc=%0d row=%0d data=0",
                 i, obs_q[i].cyc, obs_q[i].row, obs_q[i].data, exp_q[i].cyc, exp_q[i].row);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      writeValid = 1'($urandom_range(0, 1));
      writeRowIn = RB'($urandom_range(0, 7));
      writeCol   = CB'($urandom_range(0, NC - 1));
      readValid  = 1'($urandom_range(0, 1));
      readRowIn  = RB'($urandom_range(0, 7));
      newEvent   = ($urandom_range(0, 11) == 0);
      tick();
      n_cmp++;
      if (last_wrdy !== exp_wrdy_l || last_rrdy !== exp_rrdy_l || last_evt !== exp_evt_l) begin
        n_fail++;
        $display("FAIL random_ctrl cyc %0d: got wrdy=%b rrdy=%b evt=%0d required %b %b %0d", cyc,
                 last_wrdy, last_rrdy, last_evt, exp_wrdy_l, exp_rrdy_l, exp_evt_l);
      end
    end
    writeValid = 1'b0; readValid = 1'b0; newEvent = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL random_reads count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_read[%0d]: got cyc=%0d row=%0d data=%h required cyc=%0d row=%0d data=%h",
                 i, obs_q[i].cyc, obs_q[i].row, obs_q[i].data, exp_q[i].cyc, exp_q[i].row,
                 exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_new_event();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
